// File: rtl/clock_pkg.sv
// Shared clock-domain types and helpers: chime FSM states, hour constants and
// BCD-to-binary conversion reused by the display path.
package clock_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        BEEP,
        GAP,
        DONE
    } chime_state_t;

    localparam int         HOURS_PER_HALF_DAY = 12;
    localparam logic [7:0] MAX_HOUR_BCD       = 8'h23;

    // Wide enough for any pair of nibbles, so malformed BCD still compares sanely.
    function automatic logic [7:0] bcd_to_bin(input logic [7:0] bcd);
        return ({4'd0, bcd[7:4]} * 8'd10) + {4'd0, bcd[3:0]};
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer followed by a rising-edge detector; pulse is high for
// one clk cycle per rising edge of async_in.
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic pulse
);

    logic meta;
    logic sync;
    logic sync_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta   <= async_in;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    // Combinational so the FSM reacts in the same cycle the edge is seen.
    assign pulse = sync & ~sync_d;

endmodule

// File: rtl/hour_chime_ctrl.sv
// Hourly chime sequencer: on each hour event, beeps the buzzer once per hour on
// a 12-hour dial, with beep and gap lengths timed in tick_en pulses.
module hour_chime_ctrl
    import clock_pkg::*;
#(
    parameter int BEEP_TICKS = 2,
    parameter int GAP_TICKS  = 2,
    parameter int TCNT_W     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_en,
    input  logic       hour_changed,
    input  logic [7:0] hour,
    input  logic       chime_en,
    output logic       buzzer,
    output logic       busy,
    output logic [3:0] beep_idx,
    output logic       done,
    output logic       err
);

    localparam logic [TCNT_W-1:0] BEEP_LAST = TCNT_W'(BEEP_TICKS - 1);
    localparam logic [TCNT_W-1:0] GAP_LAST  = TCNT_W'(GAP_TICKS - 1);

    chime_state_t      state;
    chime_state_t      next_state;
    logic              trig;
    logic [7:0]        hour_q;
    logic [7:0]        hour_bin;
    logic [7:0]        half_bin;
    logic              hour_valid;
    logic [3:0]        chime_count;
    logic [3:0]        remaining;
    logic [TCNT_W-1:0] tcnt;

    edge_sync u_hour_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (hour_changed),
        .pulse    (trig)
    );

    // Hour decode: validity and 12-hour beep count (0 and 12 both chime 12).
    always_comb begin
        hour_bin    = bcd_to_bin(hour_q);
        hour_valid  = (hour_q[3:0] <= 4'd9) && (hour_q[7:4] <= 4'd2) &&
                      (hour_bin <= bcd_to_bin(MAX_HOUR_BCD));
        half_bin    = (hour_bin >= 8'(HOURS_PER_HALF_DAY)) ?
                      hour_bin - 8'(HOURS_PER_HALF_DAY) : hour_bin;
        chime_count = (half_bin == 8'd0) ? 4'(HOURS_PER_HALF_DAY) : 4'(half_bin);
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (trig && chime_en) next_state = LOAD;
            LOAD: next_state = (chime_en && hour_valid) ? BEEP : IDLE;
            BEEP: begin
                if (!chime_en)
                    next_state = IDLE;
                else if (tick_en && tcnt == BEEP_LAST)
                    next_state = (remaining == 4'd1) ? DONE : GAP;
            end
            GAP: begin
                if (!chime_en)
                    next_state = IDLE;
                else if (tick_en && tcnt == GAP_LAST)
                    next_state = BEEP;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from next_state so they line up with the new state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            buzzer <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= next_state;
            buzzer <= (next_state == BEEP);
            busy   <= (next_state != IDLE);
            done   <= (next_state == DONE);
            err    <= (state == LOAD) && chime_en && !hour_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hour_q    <= '0;
            remaining <= '0;
            tcnt      <= '0;
            beep_idx  <= '0;
        end else begin
            case (state)
                IDLE: if (trig && chime_en) hour_q <= hour;
                LOAD: begin
                    if (chime_en && hour_valid) begin
                        remaining <= chime_count;
                        beep_idx  <= 4'd1;
                        tcnt      <= '0;
                    end
                end
                BEEP: begin
                    if (chime_en && tick_en) begin
                        if (tcnt == BEEP_LAST) begin
                            tcnt <= '0;
                            if (remaining != 4'd1) remaining <= remaining - 4'd1;
                        end else begin
                            tcnt <= tcnt + TCNT_W'(1);
                        end
                    end
                end
                GAP: begin
                    if (chime_en && tick_en) begin
                        if (tcnt == GAP_LAST) begin
                            tcnt <= '0;
                            if (beep_idx < 4'd12) beep_idx <= beep_idx + 4'd1;
                        end else begin
                            tcnt <= tcnt + TCNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
